muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers, sitting beside the ALU in the execute stage. It consumes the same two 32-bit register operands the ALU logic components receive and executes MULT, MULTU, DIV and DIVU over 33 cycles. Results land in HI/LO, which MFHI/MFLO read and MTHI/MTLO write. The controller stalls the pipeline on `busy`.

## Interface
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: request an operation; accepted only when `busy`=0.
- `op` in 2: operation code, 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with `start`.
- `a` in WIDTH: operand rs (multiplicand or dividend); sampled with `start`.
- `b` in WIDTH: operand rt (multiplier or divisor); sampled with `start`.
- `hi_we` in 1: MTHI write enable.
- `lo_we` in 1: MTLO write enable.
- `wdata` in WIDTH: MTHI/MTLO data.
- `busy` out 1: operation in flight.
- `done` out 1: one-cycle pulse when HI/LO receive a result.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

## Operation
- FSM states:
  - IDLE: `start` moves to RUN; load operand magnitudes (signed ops take abs value), record result signs, clear the 64-bit accumulator, count=0.
  - RUN: one radix-2 step per cycle. Multiply uses shift-add; divide uses restoring shift-subtract. count increments; after count=WIDTH-1, go to FIX.
  - FIX: apply sign correction, write HI/LO, go to IDLE, pulse `done`.
- Multiply result: {hi,lo} = full 64-bit product, signed for MULT, unsigned for MULTU.
- Divide result: lo = quotient, hi = remainder. For DIV, the quotient sign is sign(a)^sign(b) and the remainder sign follows the dividend. 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divide by zero (no trap): lo=0xFFFFFFFF, hi=a, for both DIV and DIVU.
- MTHI/MTLO:
  - Honoured only when `busy`=0; dropped while busy.
  - `hi_we` together with `start` in IDLE: the write takes effect at that edge, and the later result overwrites it.
- `start` while busy is ignored, with no queuing.

## Timing
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, FSM in IDLE.
- Edge E0 accepts `start`. `busy` is high from after E0 until after E33.
- Edges E1..E32 perform the 32 iterations. E33 (the FIX state) writes HI/LO.
- `done`=1 for exactly the cycle after E33, with `busy`=0. A new `start` may be accepted at E34; the effective throughput is one operation per 34 cycles.
- HI/LO outputs are registered and change only at E33 or on an MTHI/MTLO edge.
- `reset` mid-operation: immediate return to IDLE with all outputs at reset values; the partial result is discarded.

## Configuration
- `MULDIV_DIV_EN`
  - Defined: full behaviour as above.
  - Undefined: divider datapath and restoring logic omitted.
  - `start` with op[1]=1 is accepted without entering RUN. `busy` stays 0, `done` pulses the next cycle, and HI/LO are unchanged.

## Structure
- `muldiv_pkg` holds:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - the state enum: IDLE, RUN, FIX;
  - the `WIDTH` default and the divide-by-zero quotient constant.
- One sub-module, `muldiv_step`: combinational single iteration. Inputs are accumulator, operand and op class; output is the next accumulator. Instantiated once inside `muldiv_unit`.

## Test plan
- MULT a=0xFFFFFFFF, b=0x00000002 -> after 33 cycles `done`, hi=0xFFFFFFFF, lo=0xFFFFFFFE. Same operands with MULTU -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=0x00000007.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000.
- Overlapping requests:
  - MULTU 3*5 accepted; second `start` (DIVU 100/7) at E5 -> ignored; final hi=0, lo=15, single `done`.
  - `hi_we` with wdata=0xAAAA at E10 -> dropped, hi stays 0.
- MULTU 0xFFFFFFFF*0xFFFFFFFF with `reset` asserted at E12 -> `busy`/`done`/hi/lo=0 immediately. A new MULTU 2*3 then completes with lo=6 at the proper 33-cycle latency.
- Idle `lo_we` wdata=0x12345678 -> lo=0x12345678 next edge, hi unchanged. With `MULDIV_DIV_EN` undefined, DIVU start -> `done` next cycle, `busy` never high, HI/LO unchanged.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared op encodings, FSM states and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [WIDTH_DEF-1:0] DIV0_QUOT = '1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: MSB-first shift-add multiply or restoring shift-subtract divide.
// The divide path is present only when MULDIV_DIV_EN is defined.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               bit_in,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [2*WIDTH-1:0] mul_next;

  assign mul_next = {acc[2*WIDTH-2:0], 1'b0} + (bit_in ? {{WIDTH{1'b0}}, operand} : '0);

`ifdef MULDIV_DIV_EN
  // Upper half is the partial remainder, lower half collects quotient bits.
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  assign rem_sh = {acc[2*WIDTH-1:WIDTH], bit_in};
  assign diff   = rem_sh - {1'b0, operand};

  always_comb begin
    acc_next = mul_next;
    if (is_div) begin
      if (!diff[WIDTH]) acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else              acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end
`else
  logic unused_is_div;

  assign unused_is_div = is_div;
  assign acc_next      = mul_next;
`endif

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO, 33 cycles per operation.
// Divide support is compiled in only when MULDIV_DIV_EN is defined.
import muldiv_pkg::*;

module muldiv_unit #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  state_t               state, state_next;
  logic [CW-1:0]        count;
  logic                 done_next;
  logic                 signed_op, div_op, launch;
  logic                 sign_a, sign_b;
  logic [2*WIDTH-1:0]   acc, acc_step;
  logic [WIDTH-1:0]     shreg, opnd;
  logic                 is_div, neg_q, neg_r, div0;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     hi_res, lo_res;

  function automatic logic [WIDTH-1:0] sign_fix_w(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] sign_fix_dw(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign div_op    = !((op == OP_MULT) || (op == OP_MULTU));
  assign sign_a    = signed_op & a[WIDTH-1];
  assign sign_b    = signed_op & b[WIDTH-1];
  assign busy      = (state != IDLE);
  assign launch    = (state == IDLE) && (state_next == RUN);

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef MULDIV_DIV_EN
          state_next = RUN;
`else
          // Without a divider, divide requests complete immediately and leave HI/LO alone.
          if (div_op) done_next = 1'b1;
          else        state_next = RUN;
`endif
        end
      end
      RUN: begin
        if (count == CW'(WIDTH-1)) state_next = FIX;
      end
      FIX: begin
        state_next = IDLE;
        done_next  = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      done  <= 1'b0;
      count <= '0;
    end else begin
      state <= state_next;
      done  <= done_next;
      if (launch)              count <= '0;
      else if (state == RUN)   count <= count + 1'b1;
    end
  end

  // Operands enter as magnitudes; result signs are re-applied in FIX.
  always_ff @(posedge clk) begin
    if (launch) begin
      acc    <= '0;
      is_div <= div_op;
      neg_q  <= sign_a ^ sign_b;
      neg_r  <= sign_a;
      div0   <= div_op && (b == '0);
      if (div_op) begin
        shreg <= sign_fix_w(a, sign_a);
        opnd  <= sign_fix_w(b, sign_b);
      end else begin
        shreg <= sign_fix_w(b, sign_b);
        opnd  <= sign_fix_w(a, sign_a);
      end
    end else if (state == RUN) begin
      acc   <= acc_step;
      shreg <= shreg << 1;
    end
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .operand  (opnd),
    .bit_in   (shreg[WIDTH-1]),
    .is_div   (is_div),
    .acc_next (acc_step)
  );

  always_comb begin
    prod_fix = sign_fix_dw(acc, neg_q);
    hi_res   = prod_fix[2*WIDTH-1:WIDTH];
    lo_res   = prod_fix[WIDTH-1:0];
    if (is_div) begin
      // Zero divisor: remainder path already restores the dividend, quotient is forced.
      hi_res = sign_fix_w(acc[2*WIDTH-1:WIDTH], neg_r);
      lo_res = div0 ? WIDTH'(DIV0_QUOT) : sign_fix_w(acc[WIDTH-1:0], neg_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (state == FIX) begin
      hi <= hi_res;
      lo <= lo_res;
    end else if (state == IDLE) begin
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit; divide vectors apply when MULDIV_DIV_EN is defined,
// otherwise the immediate-completion behaviour of divide requests is checked.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic [31:0] exp_hi, exp_lo;
  int          lat, done_cnt, done_at;
  logic        bsy;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one operation and wait (bounded) for done; lat stays 0 on timeout.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lt, output logic bs);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lt = 0;
    bs = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done) begin
        lt = k;
        break;
      end
      bs = bs | busy;
    end
  endtask

  task automatic check_result(input string tag, input logic [31:0] eh, input logic [31:0] el);
    chk({tag, "_latency"}, 64'(lat), 64'd34);
    chk({tag, "_busy_seen"}, 64'(bsy), 64'd1);
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    chk({tag, "_hi"}, 64'(hi), 64'(eh));
    chk({tag, "_lo"}, 64'(lo), 64'(el));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    reset = 1'b0;

    run_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, lat, bsy);
    check_result("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, lat, bsy);
    check_result("multu", 32'h0000_0001, 32'hFFFF_FFFE);
    exp_hi = 32'h0000_0001;
    exp_lo = 32'hFFFF_FFFE;

`ifdef MULDIV_DIV_EN
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, lat, bsy);
    check_result("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(2'b11, 32'h0000_0007, 32'h0000_0000, lat, bsy);
    check_result("divu_zero", 32'h0000_0007, 32'hFFFF_FFFF);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, bsy);
    check_result("div_ovf", 32'h0000_0000, 32'h8000_0000);
    exp_hi = 32'h0000_0000;
    exp_lo = 32'h8000_0000;
`else
    run_op(2'b11, 32'h0000_0064, 32'h0000_0007, lat, bsy);
    chk("nodiv_latency", 64'(lat), 64'd1);
    chk("nodiv_busy_seen", 64'(bsy), 64'd0);
    chk("nodiv_busy_at_done", 64'(busy), 64'd0);
    chk("nodiv_hi", 64'(hi), 64'(exp_hi));
    chk("nodiv_lo", 64'(lo), 64'(exp_lo));
    @(negedge clk);
    chk("nodiv_done_pulse", 64'(done), 64'd0);
`endif

    // Idle MTLO then MTHI
    lo_we = 1'b1; wdata = 32'h1234_5678;
    @(posedge clk);
    #1 lo_we = 1'b0;
    chk("mtlo_lo", 64'(lo), 64'h1234_5678);
    chk("mtlo_hi", 64'(hi), 64'(exp_hi));
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1 hi_we = 1'b0;
    chk("mthi_hi", 64'(hi), 64'hCAFE_F00D);
    chk("mthi_lo", 64'(lo), 64'h1234_5678);

    // Overlapping start and MTHI while busy are both dropped
    @(negedge clk);
    op = 2'b01; a = 32'd3; b = 32'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    done_cnt = 0;
    done_at  = 0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        done_at = k;
      end
      if (k == 5)  begin op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1; end
      if (k == 6)  start = 1'b0;
      if (k == 10) begin hi_we = 1'b1; wdata = 32'h0000_AAAA; end
      if (k == 11) hi_we = 1'b0;
      if (k == 12) chk("busy_mthi_dropped", 64'(hi), 64'hCAFE_F00D);
    end
    chk("ovl_done_count", 64'(done_cnt), 64'd1);
    chk("ovl_done_at", 64'(done_at), 64'd34);
    chk("ovl_hi", 64'(hi), 64'd0);
    chk("ovl_lo", 64'(lo), 64'd15);

    // Reset mid-operation
    @(negedge clk);
    op = 2'b01; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k < 12; k++) @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op(2'b01, 32'd2, 32'd3, lat, bsy);
    check_result("post_rst", 32'd0, 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
